// File: rtl/dragonfang_pkg.sv
// Shared vector-datapath types for the execution / writeback pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dragonfang_pkg;

  parameter int VLEN          = 64;
  parameter int PKG_TAG_WIDTH = 5;

  typedef struct packed {
    logic [PKG_TAG_WIDTH-1:0] tag;
    logic [VLEN-1:0]          data;
  } data_packet_t;

endpackage

// File: rtl/vector_writeback_buffer.sv
// Purpose: in-order result FIFO between vector execution and the VRF write port,
//          plus a register holding the last committed result for the bypass path.
// Latency: push at edge N shows on write_* in cycle N+1; a commit at edge M is on bypass_* from M+1.
// Backpressure: input_ready = (count < DEPTH) from registered count only; write_ready low stalls the head.
//
// Ports:
//   clock, reset_n        clock, async active-low reset
//   flush                 synchronous discard of all queued results (wins over push/commit)
//   input_port/_valid/_ready   result stream from the execution stage
//   write_enable/_tag/_data/_ready   register-file write port (head of FIFO)
//   bypass_port/_valid    last committed result, fed back to the execution bypass input
//   occupancy             number of queued entries
module vector_writeback_buffer #(
  parameter int DEPTH     = 4,
  // Must match dragonfang_pkg::PKG_TAG_WIDTH, which sizes data_packet_t.tag.
  parameter int TAG_WIDTH = dragonfang_pkg::PKG_TAG_WIDTH,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  dragonfang_pkg::data_packet_t  input_port,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic                          write_enable,
  output logic [TAG_WIDTH-1:0]          write_tag,
  output logic [dragonfang_pkg::VLEN-1:0] write_data,
  input  logic                          write_ready,
  output dragonfang_pkg::data_packet_t  bypass_port,
  output logic                          bypass_valid,
  output logic [CW-1:0]                 occupancy
);

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  dragonfang_pkg::data_packet_t r_mem [DEPTH];
  logic [PW-1:0]                r_rptr;
  logic [PW-1:0]                r_wptr;
  logic [CW-1:0]                r_count;
  dragonfang_pkg::data_packet_t r_bypass;
  logic                         r_bypass_vld;

  logic                         w_push;
  logic                         w_pop;
  dragonfang_pkg::data_packet_t w_head;

  // A full buffer refuses input even when the head drains in the same cycle,
  // keeping input_ready independent of write_ready.
  assign input_ready  = (r_count < LP_DEPTH);
  assign write_enable = (r_count != '0);
  assign occupancy    = r_count;
  assign bypass_port  = r_bypass;
  assign bypass_valid = r_bypass_vld;

  assign w_push = input_valid && input_ready && !flush;
  assign w_pop  = write_enable && write_ready && !flush;

  assign w_head     = r_mem[r_rptr];
  // Head mux is the only combinational path to outputs; forced to 0 when empty.
  assign write_tag  = write_enable ? w_head.tag  : '0;
  assign write_data = write_enable ? w_head.data : '0;

  // Storage is not reset; entries are only observable through count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= input_port;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_bypass     <= '0;
      r_bypass_vld <= 1'b0;
    end else if (flush) begin
      // Bypass data is left in place; only its valid flag is dropped.
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_bypass_vld <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr       <= r_rptr + 1'b1;
        r_bypass     <= w_head;
        r_bypass_vld <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_writeback_buffer.sv
// Scoreboard bench for vector_writeback_buffer: stimulus queues expected writes,
// a negedge monitor pops and compares each register-file write.
// Directed checks cover reset, latency, full/empty boundaries, flush and async reset.
module tb_vector_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int VLEN  = dragonfang_pkg::VLEN;

  typedef dragonfang_pkg::data_packet_t pkt_t;

  logic              clock;
  logic              reset_n;
  logic              flush;
  pkt_t              input_port;
  logic              input_valid;
  logic              input_ready;
  logic              write_enable;
  logic [4:0]        write_tag;
  logic [VLEN-1:0]   write_data;
  logic              write_ready;
  pkt_t              bypass_port;
  logic              bypass_valid;
  logic [2:0]        occupancy;

  int   tests;
  int   fails;
  pkt_t exp_q[$];

  vector_writeback_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .input_port   (input_port),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .write_enable (write_enable),
    .write_tag    (write_tag),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .bypass_port  (bypass_port),
    .bypass_valid (bypass_valid),
    .occupancy    (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input int t, input logic [VLEN-1:0] d);
    pkt_t p;
    p.tag  = 5'(t);
    p.data = d;
    return p;
  endfunction

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Offer one result for one edge; record it as expected if it will be taken.
  task automatic drive(input int t, input logic [VLEN-1:0] d);
    input_valid = 1'b1;
    input_port  = mk(t, d);
    if (input_ready && !flush) exp_q.push_back(mk(t, d));
    cyc();
  endtask

  task automatic idle();
    input_valid = 1'b0;
    input_port  = '0;
  endtask

  // Monitor: a write commits at the next edge when this holds.
  always @(negedge clock) begin
    if (reset_n && write_enable && write_ready && !flush) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got tag %0d, required no write", write_tag);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("wr_tag", 80'(write_tag), 80'(e.tag));
        chk("wr_data", 80'(write_data), 80'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    bit got;
    tests       = 0;
    fails       = 0;
    reset_n     = 1'b0;
    flush       = 1'b0;
    input_valid = 1'b0;
    input_port  = '0;
    write_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_we",   80'(write_enable), 80'(0));
    chk("rst_ir",   80'(input_ready),  80'(1));
    chk("rst_occ",  80'(occupancy),    80'(0));
    chk("rst_bv",   80'(bypass_valid), 80'(0));
    chk("rst_bp",   80'(bypass_port),  80'(0));
    chk("rst_wtag", 80'(write_tag),    80'(0));
    #1 reset_n = 1'b1;
    cyc();

    // Single result after reset
    write_ready = 1'b1;
    drive(3, {8{8'hA5}});
    idle();
    chk("t1_we",    80'(write_enable), 80'(1));
    chk("t1_wtag",  80'(write_tag),    80'(3));
    chk("t1_wdata", 80'(write_data),   80'({8{8'hA5}}));
    chk("t1_occ1",  80'(occupancy),    80'(1));
    cyc();
    chk("t1_bv",    80'(bypass_valid),     80'(1));
    chk("t1_btag",  80'(bypass_port.tag),  80'(3));
    chk("t1_bdata", 80'(bypass_port.data), 80'({8{8'hA5}}));
    chk("t1_occ0",  80'(occupancy),        80'(0));
    chk("t1_we0",   80'(write_enable),     80'(0));

    // Fill and back-pressure
    write_ready = 1'b0;
    for (int t = 1; t <= 4; t++) drive(t, 64'(t * 'h11));
    chk("fill_occ", 80'(occupancy),   80'(4));
    chk("fill_ir",  80'(input_ready), 80'(0));
    chk("fill_head_tag", 80'(write_tag), 80'(1));
    drive(5, 64'h55);
    chk("fill_refused_occ", 80'(occupancy), 80'(4));
    chk("fill_head_stable", 80'(write_tag), 80'(1));
    write_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      got = input_ready;
      drive(5, 64'h55);
    end
    idle();
    chk("fill_tag5_accepted", 80'(got), 80'(1));
    repeat (6) cyc();
    chk("fill_drained_occ", 80'(occupancy),       80'(0));
    chk("fill_last_bypass", 80'(bypass_port.tag), 80'(5));

    // Streaming: each result is at the head one cycle after acceptance
    for (int t = 0; t < 16; t++) begin
      drive(t + 8, 64'h1000 + 64'(t));
      chk("stream_occ",  80'(occupancy), 80'(1));
      chk("stream_head", 80'(write_tag), 80'(t + 8));
    end
    idle();
    cyc();
    chk("stream_end_occ",  80'(occupancy),       80'(0));
    chk("stream_end_btag", 80'(bypass_port.tag), 80'(23));

    // Same-tag results are both written, in order
    drive(7, 64'h1);
    drive(7, 64'h2);
    idle();
    cyc();
    chk("same_bdata", 80'(bypass_port.data), 80'(2));
    chk("same_btag",  80'(bypass_port.tag),  80'(7));
    chk("same_occ",   80'(occupancy),        80'(0));

    // Flush mid-operation with a push and commit handshake offered
    write_ready = 1'b0;
    drive(10, 64'hA);
    drive(11, 64'hB);
    drive(12, 64'hC);
    chk("fl_occ3", 80'(occupancy), 80'(3));
    flush       = 1'b1;
    write_ready = 1'b1;
    drive(13, 64'hD);
    flush = 1'b0;
    idle();
    exp_q.delete();
    chk("fl_occ",   80'(occupancy),       80'(0));
    chk("fl_we",    80'(write_enable),    80'(0));
    chk("fl_bv",    80'(bypass_valid),    80'(0));
    chk("fl_ir",    80'(input_ready),     80'(1));
    chk("fl_btag",  80'(bypass_port.tag), 80'(7));
    cyc();
    chk("fl_not_stored", 80'(occupancy), 80'(0));

    // Async reset mid-operation
    write_ready = 1'b0;
    drive(20, 64'h20);
    drive(21, 64'h21);
    drive(22, 64'h22);
    write_ready = 1'b1;
    idle();
    cyc();
    write_ready = 1'b0;
    chk("ar_occ2", 80'(occupancy),    80'(2));
    chk("ar_bv1",  80'(bypass_valid), 80'(1));
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_we",  80'(write_enable), 80'(0));
    chk("ar_ir",  80'(input_ready),  80'(1));
    chk("ar_bv",  80'(bypass_valid), 80'(0));
    chk("ar_occ", 80'(occupancy),    80'(0));
    chk("ar_bp",  80'(bypass_port),  80'(0));
    reset_n = 1'b1;
    cyc();

    write_ready = 1'b1;
    drive(3, {8{8'hA5}});
    idle();
    chk("ar_t1_we",   80'(write_enable), 80'(1));
    chk("ar_t1_wtag", 80'(write_tag),    80'(3));
    cyc();
    chk("ar_t1_bv",   80'(bypass_valid),    80'(1));
    chk("ar_t1_btag", 80'(bypass_port.tag), 80'(3));
    chk("ar_t1_occ",  80'(occupancy),       80'(0));

    cyc();
    chk("sb_empty", 80'(exp_q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_writeback_buffer.md
# vector_writeback_buffer

Result-side counterpart of the vector execution stage. It accepts `data_packet_t` results (destination tag + VLEN-bit data) from the execution output, queues them in a small in-order FIFO and drains them into the vector register file write port. It also drives the execution stage's bypass input with the most recently committed result, so it closes the forwarding loop.

## Interface

Parameters:

- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and ≥ 2.
- `TAG_WIDTH`, default 5: width of `data_packet_t.tag` (32 vector registers).
- `VLEN`, taken from `dragonfang_pkg`: data width of `data_packet_t.data`.

Ports (clock and reset first):

- `clock`  in  1  single clock for the block; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush; discards all queued results.
- `input_port`  in  `data_packet_t`  result from the execution stage (tag, data).
- `input_valid`  in  1  `input_port` carries a result this cycle.
- `input_ready`  out  1  buffer can accept a result this cycle.
- `write_enable`  out  1  register-file write request; head entry is valid.
- `write_tag`  out  `TAG_WIDTH`  destination register of the head entry.
- `write_data`  out  `VLEN`  data of the head entry.
- `write_ready`  in  1  register file accepts the write this cycle.
- `bypass_port`  out  `data_packet_t`  last committed result; goes to the execution stage bypass input.
- `bypass_valid`  out  1  `bypass_port` holds a committed result.
- `occupancy`  out  `$clog2(DEPTH+1)`  number of queued entries.

## Operation

- **Storage:** `DEPTH`-entry circular FIFO, plus read pointer, write pointer and count register.
- **Pointer wrap:** pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- **Push:** occurs when `input_valid && input_ready && !flush`. The entry is written at the write pointer, then the write pointer increments.
- **input_ready:** `input_ready = (count < DEPTH)`. It is combinational from registered count only and has no dependence on `write_ready`. A full buffer refuses input even if a pop happens in the same cycle.
- **Write port:** `write_enable = (count != 0)`. `write_tag` and `write_data` come directly from the entry at the read pointer. They read 0 when empty.
- **Commit (pop):** occurs when `write_enable && write_ready && !flush`. The read pointer increments.
- **Bypass update on commit:** `bypass_port <= {head tag, head data}` and `bypass_valid <= 1`.
- **Simultaneous push and commit:** count is unchanged and both pointers advance.
- **Ordering:** results commit strictly in acceptance order. Entries with the same tag are not coalesced; each one is written.
- **Flush:** has priority over push and commit. It sets count to 0 and both pointers to 0, and clears `bypass_valid` to 0. A commit handshake presented in the flush cycle is void and must not update the bypass register.
- **Input packing:** `input_port` is not inspected beyond storage. The tag is passed through unchanged.
- **Reset (async, `reset_n` low), applies immediately:**
  - count, pointers, `occupancy` = 0.
  - `write_enable` = 0, `input_ready` = 1.
  - `bypass_valid` = 0, `bypass_port` = all zeros.
  - FIFO storage contents need not be cleared.
  - Reset mid-operation discards all queued results, with the same result as flush.

## Timing

- **Latency:** a result pushed at edge N appears on `write_enable` / `write_tag` / `write_data` in cycle N+1. There is no combinational input-to-write path.
- **Commit timing:**
  - A commit at edge M makes the result visible on `bypass_port` / `bypass_valid` from cycle M+1.
  - The next FIFO entry appears on the write port from cycle M+1.
- **Throughput:** one push and one commit per cycle, sustained while 0 < count < DEPTH.
- **Full boundary:** at count = DEPTH, `input_ready` = 0 for that whole cycle. After a commit it returns to 1 in the next cycle.
- **Empty boundary:** at count = 0, `write_enable` = 0 and `write_ready` is ignored.
- **Back-pressure from register file:** holding `write_ready` low stalls the head. Outputs stay stable and the FIFO fills until `input_ready` drops.
- **Interface timing:** all outputs are registered or driven from registered state, except the FIFO-head read mux.

## Test plan

- **Single result after reset:** push {tag 3, data 0xA5..A5} with `write_ready` = 1.
  - Cycle +1: `write_enable` = 1, `write_tag` = 3.
  - Cycle +2: `bypass_valid` = 1, `bypass_port.tag` = 3, `occupancy` = 0.
- **Fill and back-pressure:** with `write_ready` = 0, push tags 1..5 on consecutive cycles.
  - Tags 1–4 are accepted; `input_ready` = 0 when tag 5 is offered; `occupancy` = 4.
  - Raise `write_ready`: writes appear as 1, 2, 3, 4 in order, and tag 5 is then accepted.
- **Streaming:** push 16 results back-to-back with `write_ready` = 1.
  - Each result is written exactly one cycle after acceptance.
  - `occupancy` stays at 1, the pointers wrap cleanly, and no bubbles occur.
- **Same-tag results:** push tag 7 with data 0x1, then tag 7 with data 0x2.
  - Two writes occur in that order.
  - Final `bypass_port.data` = 0x2.
- **Flush mid-operation:** queue 3 entries, then assert `flush` together with `input_valid` and `write_ready`.
  - Next cycle: `occupancy` = 0, `write_enable` = 0, `bypass_valid` = 0.
  - The entry offered during flush is not stored.
- **Async reset mid-operation:** with 2 entries queued and `bypass_valid` = 1, pulse `reset_n` low between clock edges.
  - Outputs clear immediately, with no clock needed: `write_enable` = 0, `input_ready` = 1, `bypass_valid` = 0.
  - After release, a new push behaves exactly as in the single-result test.
